ram_frame_loader: RTL and testbench

//  Upstream stage of the four-bank solver RAM: accepts one ODE problem frame as a 64-bit valid/ready word

---
 rtl/ram_frame_loader_pkg.sv | 55 +++++
 rtl/ram_frame_loader_counter.sv | 51 +++++
 rtl/ram_frame_loader.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ram_frame_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_frame_loader_pkg.sv
// ram_frame_loader_pkg: state encoding, solver RAM address map
// and header field layout shared by the frame loader files.
package ram_frame_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_WN,
        S_WM,
        S_H,
        S_ERR,
        S_T,
        S_U0,
        S_A,
        S_B,
        S_X,
        S_DONE,
        S_BAD
    } state_t;

    // bank1: U0 at 0..N-1, scalars and time points above it
    localparam int MAP_B1_N_ADDR   = 900;
    localparam int MAP_B1_M_ADDR   = 901;
    localparam int MAP_B1_T_BASE   = 902;

    // bank4: X at 0..N-1, scalars and time points above it
    localparam int MAP_B4_H_ADDR   = 50;
    localparam int MAP_B4_N_ADDR   = 51;
    localparam int MAP_B4_ERR_ADDR = 52;
    localparam int MAP_B4_T_BASE   = 53;

    // header word field positions
    localparam int HDR_N_LSB  = 0;
    localparam int HDR_M_LSB  = 8;
    localparam int HDR_T_LSB  = 16;
    localparam int HDR_NM_W   = 6;
    localparam int HDR_T_W    = 5;

    // linear counter covers the largest section (50*50 words)
    localparam int CNT_W = 12;
    localparam int ROW_W = 6;

    function automatic logic hdr_valid(
        input logic [HDR_NM_W-1:0] n,
        input logic [HDR_NM_W-1:0] m,
        input logic [HDR_T_W-1:0]  tc,
        input int                  max_n,
        input int                  max_t
    );
        return (n != '0) && (int'(n) <= max_n) &&
               (int'(m) <= max_n) &&
               (tc != '0) && (int'(tc) <= max_t);
    endfunction

endpackage

// File: rtl/ram_frame_loader_counter.sv
// loader_section_counter: row/col/linear position inside one
// frame section; last flags the final word of the section.
module loader_section_counter
    import ram_frame_loader_pkg::*;
#(
    parameter int LW = CNT_W,
    parameter int RW = ROW_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          adv,
    input  logic [RW-1:0] row_max,
    input  logic [RW-1:0] col_max,
    output logic [LW-1:0] lin,
    output logic          last
);

    logic [RW-1:0] row_q;
    logic [RW-1:0] col_q;
    logic [RW-1:0] row_max_q;
    logic [RW-1:0] col_max_q;

    // load restarts the section; adv steps col, wrapping into row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lin       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            row_max_q <= '0;
            col_max_q <= '0;
        end else if (load) begin
            lin       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            row_max_q <= row_max;
            col_max_q <= col_max;
        end else if (adv) begin
            lin <= lin + LW'(1);
            if (col_q == col_max_q) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + RW'(1);
            end
        end
    end

    assign last = (row_q == row_max_q) && (col_q == col_max_q);

endmodule

// File: rtl/ram_frame_loader.sv
// ram_frame_loader: takes one ODE problem frame off a valid/ready
// stream, checks the header and scatters words over four RAM banks.
module ram_frame_loader
    import ram_frame_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int AW1         = 10,
    parameter int AW2         = 12,
    parameter int AW3         = 12,
    parameter int AW4         = 7,
    parameter int MAX_N       = 50,
    parameter int MAX_T       = 16,
    parameter int B1_N_ADDR   = MAP_B1_N_ADDR,
    parameter int B1_M_ADDR   = MAP_B1_M_ADDR,
    parameter int B1_T_BASE   = MAP_B1_T_BASE,
    parameter int B4_H_ADDR   = MAP_B4_H_ADDR,
    parameter int B4_N_ADDR   = MAP_B4_N_ADDR,
    parameter int B4_ERR_ADDR = MAP_B4_ERR_ADDR,
    parameter int B4_T_BASE   = MAP_B4_T_BASE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  hdr_err,
    output logic [AW1-1:0]        address_1,
    output logic [DATA_WIDTH-1:0] data_write_1,
    output logic                  WR_signal_1,
    output logic [AW2-1:0]        address_2,
    output logic [DATA_WIDTH-1:0] data_write_2,
    output logic                  WR_signal_2,
    output logic [AW3-1:0]        address_3,
    output logic [DATA_WIDTH-1:0] data_write_3,
    output logic                  WR_signal_3,
    output logic [AW4-1:0]        address_4,
    output logic [DATA_WIDTH-1:0] data_write_4,
    output logic                  WR_signal_4
);

    state_t state_q;
    state_t state_d;

    logic [HDR_NM_W-1:0] n_q;
    logic [HDR_NM_W-1:0] m_q;
    logic [HDR_T_W-1:0]  tc_q;
    logic                hdr_err_q;

    logic [HDR_NM_W-1:0] hdr_n;
    logic [HDR_NM_W-1:0] hdr_m;
    logic [HDR_T_W-1:0]  hdr_tc;
    logic                hdr_ok;

    logic accept;
    logic idle_like;

    logic             cnt_load;
    logic [ROW_W-1:0] row_max_d;
    logic [ROW_W-1:0] col_max_d;
    logic [CNT_W-1:0] lin;
    logic             last;

    logic                  wr1_d;
    logic                  wr2_d;
    logic                  wr3_d;
    logic                  wr4_d;
    logic [AW1-1:0]        a1_d;
    logic [AW2-1:0]        a2_d;
    logic [AW3-1:0]        a3_d;
    logic [AW4-1:0]        a4_d;
    logic [DATA_WIDTH-1:0] d1_d;
    logic [DATA_WIDTH-1:0] d4_d;

    assign hdr_n  = in_data[HDR_N_LSB +: HDR_NM_W];
    assign hdr_m  = in_data[HDR_M_LSB +: HDR_NM_W];
    assign hdr_tc = in_data[HDR_T_LSB +: HDR_T_W];
    assign hdr_ok = hdr_valid(hdr_n, hdr_m, hdr_tc, MAX_N, MAX_T);

    assign idle_like = (state_q == S_IDLE) || (state_q == S_BAD);
    assign accept    = in_valid && in_ready;

    // handshake and status decode straight from the state
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            S_HDR, S_H, S_ERR, S_T,
            S_U0, S_A, S_B, S_X: in_ready = 1'b1;
            default:             in_ready = 1'b0;
        endcase
    end

    assign busy    = !idle_like;
    assign done    = (state_q == S_DONE);
    assign hdr_err = hdr_err_q;

    // frame sequencing; sections end on the counter last flag
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_BAD: if (start) state_d = S_HDR;
            S_HDR:  if (accept) state_d = hdr_ok ? S_WN : S_BAD;
            S_WN:   state_d = S_WM;
            S_WM:   state_d = S_H;
            S_H:    if (accept) state_d = S_ERR;
            S_ERR:  if (accept) state_d = S_T;
            S_T:    if (accept && last) state_d = S_U0;
            S_U0:   if (accept && last) state_d = S_A;
            S_A:    if (accept && last)
                        state_d = (m_q == '0) ? S_X : S_B;
            S_B:    if (accept && last) state_d = S_X;
            S_X:    if (accept && last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // every state change restarts the counter with the new section shape
    always_comb begin
        cnt_load  = (state_d != state_q);
        row_max_d = '0;
        col_max_d = '0;
        case (state_d)
            S_T:  col_max_d = ROW_W'(tc_q) - ROW_W'(1);
            S_U0: col_max_d = n_q - ROW_W'(1);
            S_A: begin
                row_max_d = n_q - ROW_W'(1);
                col_max_d = n_q - ROW_W'(1);
            end
            S_B: begin
                row_max_d = n_q - ROW_W'(1);
                col_max_d = m_q - ROW_W'(1);
            end
            S_X:  col_max_d = n_q - ROW_W'(1);
            default: ;
        endcase
    end

    loader_section_counter #(
        .LW (CNT_W),
        .RW (ROW_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .adv     (accept),
        .row_max (row_max_d),
        .col_max (col_max_d),
        .lin     (lin),
        .last    (last)
    );

    // steer the current word (or header scalar) to its bank slot
    always_comb begin
        wr1_d = 1'b0;
        wr2_d = 1'b0;
        wr3_d = 1'b0;
        wr4_d = 1'b0;
        a1_d  = '0;
        a2_d  = '0;
        a3_d  = '0;
        a4_d  = '0;
        d1_d  = in_data;
        d4_d  = in_data;
        case (state_q)
            S_WN: begin
                wr1_d = 1'b1;
                a1_d  = AW1'(B1_N_ADDR);
                d1_d  = DATA_WIDTH'(n_q);
                wr4_d = 1'b1;
                a4_d  = AW4'(B4_N_ADDR);
                d4_d  = DATA_WIDTH'(n_q);
            end
            S_WM: begin
                wr1_d = 1'b1;
                a1_d  = AW1'(B1_M_ADDR);
                d1_d  = DATA_WIDTH'(m_q);
            end
            S_H: begin
                wr4_d = accept;
                a4_d  = AW4'(B4_H_ADDR);
            end
            S_ERR: begin
                wr4_d = accept;
                a4_d  = AW4'(B4_ERR_ADDR);
            end
            S_T: begin
                wr1_d = accept;
                a1_d  = AW1'(B1_T_BASE + int'(lin));
                wr4_d = accept;
                a4_d  = AW4'(B4_T_BASE + int'(lin));
            end
            S_U0: begin
                wr1_d = accept;
                a1_d  = AW1'(lin);
            end
            S_A: begin
                wr2_d = accept;
                a2_d  = AW2'(lin);
            end
            S_B: begin
                wr3_d = accept;
                a3_d  = AW3'(lin);
            end
            S_X: begin
                wr4_d = accept;
                a4_d  = AW4'(lin);
            end
            default: ;
        endcase
    end

    // state, latched header fields and sticky header error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            m_q       <= '0;
            tc_q      <= '0;
            hdr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_HDR && accept) begin
                n_q  <= hdr_n;
                m_q  <= hdr_m;
                tc_q <= hdr_tc;
            end
            if (idle_like && start) begin
                hdr_err_q <= 1'b0;
            end else if (state_q == S_HDR && accept && !hdr_ok) begin
                hdr_err_q <= 1'b1;
            end
        end
    end

    // registered write ports; WR lasts exactly one cycle per word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WR_signal_1  <= 1'b0;
            WR_signal_2  <= 1'b0;
            WR_signal_3  <= 1'b0;
            WR_signal_4  <= 1'b0;
            address_1    <= '0;
            address_2    <= '0;
            address_3    <= '0;
            address_4    <= '0;
            data_write_1 <= '0;
            data_write_2 <= '0;
            data_write_3 <= '0;
            data_write_4 <= '0;
        end else begin
            WR_signal_1 <= wr1_d;
            WR_signal_2 <= wr2_d;
            WR_signal_3 <= wr3_d;
            WR_signal_4 <= wr4_d;
            if (wr1_d) begin
                address_1    <= a1_d;
                data_write_1 <= d1_d;
            end
            if (wr2_d) begin
                address_2    <= a2_d;
                data_write_2 <= in_data;
            end
            if (wr3_d) begin
                address_3    <= a3_d;
                data_write_3 <= in_data;
            end
            if (wr4_d) begin
                address_4    <= a4_d;
                data_write_4 <= d4_d;
            end
        end
    end

endmodule

// File: tb/tb_ram_frame_loader.sv
// tb_ram_frame_loader: random frames against a queue of expected
// RAM writes built from the frame layout, plus literal spot checks.
module tb_ram_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready, busy, done, hdr_err;
    logic [9:0]  address_1;
    logic [11:0] address_2, address_3;
    logic [6:0]  address_4;
    logic [63:0] data_write_1, data_write_2;
    logic [63:0] data_write_3, data_write_4;
    logic        WR_signal_1, WR_signal_2;
    logic        WR_signal_3, WR_signal_4;

    ram_frame_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .busy         (busy),
        .done         (done),
        .hdr_err      (hdr_err),
        .address_1    (address_1),
        .data_write_1 (data_write_1),
        .WR_signal_1  (WR_signal_1),
        .address_2    (address_2),
        .data_write_2 (data_write_2),
        .WR_signal_2  (WR_signal_2),
        .address_3    (address_3),
        .data_write_3 (data_write_3),
        .WR_signal_3  (WR_signal_3),
        .address_4    (address_4),
        .data_write_4 (data_write_4),
        .WR_signal_4  (WR_signal_4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  wr;
        logic [11:0] a1, a2, a3, a4;
        logic [63:0] d1, d2, d3, d4;
    } ev_t;

    localparam logic [63:0] JUNK = 64'hFFFF_FFFF_FFE0_C0C0;

    ev_t         exp_q[$];
    logic [63:0] xw[$];
    logic [63:0] t_last;
    logic [63:0] mem1 [0:1023];
    logic [63:0] mem2 [0:4095];
    logic [63:0] mem3 [0:4095];
    logic [63:0] mem4 [0:127];
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int wr3_cnt = 0;
    int last_a2 = -1;
    int last_a3 = -1;
    int cyc = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic ev_t mk(int b, int a, logic [63:0] d);
        ev_t e = '0;
        e.wr[b-1] = 1'b1;
        case (b)
            1: begin e.a1 = 12'(a); e.d1 = d; end
            2: begin e.a2 = 12'(a); e.d2 = d; end
            3: begin e.a3 = 12'(a); e.d3 = d; end
            default: begin e.a4 = 12'(a); e.d4 = d; end
        endcase
        return e;
    endfunction

    function automatic logic [63:0] hdr_word(int n, int m, int tc);
        return 64'(n) | (64'(m) << 8) | (64'(tc) << 16);
    endfunction

    function automatic logic [63:0] rnd();
        return {$urandom, $urandom};
    endfunction

    // compare every observed write against the next expected one
    always @(negedge clk) begin
        logic [3:0] wr;
        ev_t e;
        wr = {WR_signal_4, WR_signal_3, WR_signal_2, WR_signal_1};
        if (wr != 4'd0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(wr), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_mask", 64'(wr), 64'(e.wr));
                if (e.wr[0] && wr[0]) begin
                    chk("addr1", 64'(address_1), 64'(e.a1));
                    chk("data1", data_write_1, e.d1);
                end
                if (e.wr[1] && wr[1]) begin
                    chk("addr2", 64'(address_2), 64'(e.a2));
                    chk("data2", data_write_2, e.d2);
                end
                if (e.wr[2] && wr[2]) begin
                    chk("addr3", 64'(address_3), 64'(e.a3));
                    chk("data3", data_write_3, e.d3);
                end
                if (e.wr[3] && wr[3]) begin
                    chk("addr4", 64'(address_4), 64'(e.a4));
                    chk("data4", data_write_4, e.d4);
                end
            end
            if (wr[0]) mem1[address_1] = data_write_1;
            if (wr[1]) begin
                mem2[address_2] = data_write_2;
                last_a2 = int'(address_2);
            end
            if (wr[2]) begin
                mem3[address_3] = data_write_3;
                last_a3 = int'(address_3);
                wr3_cnt++;
            end
            if (wr[3]) mem4[address_4] = data_write_4;
        end
        if (done) begin
            done_cnt++;
            chk("done_after_last_write", 64'(exp_q.size()), 64'd0);
            chk("busy_in_done", 64'(busy), 64'd1);
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input int gap);
        int budget;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = rnd();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int n, input int m, input int tc,
                             input int gap_mode, input int abort_at,
                             input bit a_seq, output int cycles);
        logic [63:0] w[$];
        logic [63:0] v;
        ev_t e;
        int d0, t0, gap, c;
        cycles = 0;
        xw.delete();
        w.push_back(hdr_word(n, m, tc) | (rnd() & JUNK));
        e = mk(1, 900, 64'(n));
        e.wr[3] = 1'b1;
        e.a4 = 12'(51);
        e.d4 = 64'(n);
        exp_q.push_back(e);
        exp_q.push_back(mk(1, 901, 64'(m)));
        v = rnd(); w.push_back(v); exp_q.push_back(mk(4, 50, v));
        v = rnd(); w.push_back(v); exp_q.push_back(mk(4, 52, v));
        for (int i = 0; i < tc; i++) begin
            v = rnd();
            w.push_back(v);
            e = mk(1, 902 + i, v);
            e.wr[3] = 1'b1;
            e.a4 = 12'(53 + i);
            e.d4 = v;
            exp_q.push_back(e);
            t_last = v;
        end
        for (int i = 0; i < n; i++) begin
            v = rnd(); w.push_back(v); exp_q.push_back(mk(1, i, v));
        end
        for (int i = 0; i < n * n; i++) begin
            v = a_seq ? 64'(10 + i) : rnd();
            w.push_back(v);
            exp_q.push_back(mk(2, i, v));
        end
        for (int i = 0; i < n * m; i++) begin
            v = rnd(); w.push_back(v); exp_q.push_back(mk(3, i, v));
        end
        for (int i = 0; i < n; i++) begin
            v = rnd();
            w.push_back(v);
            exp_q.push_back(mk(4, i, v));
            xw.push_back(v);
        end
        d0 = done_cnt;
        pulse_start();
        t0 = cyc;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("hdr_err_cleared", 64'(hdr_err), 64'd0);
        for (int k = 0; k < w.size(); k++) begin
            if (k == abort_at) begin
                chk("pre_abort_wr", 64'(WR_signal_2), 64'd1);
                rst_n = 1'b0;
                #1;
                chk("abort_wr", 64'({WR_signal_4, WR_signal_3,
                                     WR_signal_2, WR_signal_1}), 64'd0);
                chk("abort_addr2", 64'(address_2), 64'd0);
                chk("abort_data2", data_write_2, 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_ready", 64'(in_ready), 64'd0);
                chk("abort_done", 64'(done), 64'd0);
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
                return;
            end
            if (gap_mode == 1) gap = (k > 0) ? 1 : 0;
            else if (gap_mode == 2) gap = $urandom_range(0, 3);
            else gap = 0;
            send_word(w[k], gap);
        end
        c = 0;
        while (done_cnt == d0 && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        cycles = cyc - t0;
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic bad_hdr(input logic [63:0] h);
        int d0;
        d0 = done_cnt;
        pulse_start();
        send_word(h, 0);
        in_valid = 1'b1;
        in_data  = rnd();
        repeat (3) @(posedge clk);
        #1;
        chk("bad_hdr_err", 64'(hdr_err), 64'd1);
        chk("bad_in_ready", 64'(in_ready), 64'd0);
        chk("bad_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        chk("bad_no_done", 64'(done_cnt - d0), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc1, cyc2, w3, cdummy;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hdr_err", 64'(hdr_err), 64'd0);
        chk("rst_wr", 64'({WR_signal_4, WR_signal_3,
                           WR_signal_2, WR_signal_1}), 64'd0);
        chk("rst_addr1", 64'(address_1), 64'd0);
        rst_n = 1'b1;

        run_frame(2, 1, 2, 0, -1, 1'b1, cyc1);
        for (int i = 0; i < 4; i++)
            chk("a_lit", mem2[i], 64'(10 + i));
        chk("b1_n", mem1[900], 64'd2);
        chk("b1_m", mem1[901], 64'd1);
        chk("b4_n", mem4[51], 64'd2);

        for (int i = 0; i < 4; i++) mem2[i] = '0;
        run_frame(2, 1, 2, 1, -1, 1'b1, cyc2);
        for (int i = 0; i < 4; i++)
            chk("a_lit_toggle", mem2[i], 64'(10 + i));
        chk("toggle_slower", 64'(cyc2 >= cyc1 + 12), 64'd1);

        w3 = wr3_cnt;
        run_frame(3, 0, 1, 2, -1, 1'b0, cdummy);
        chk("m0_no_bank3", 64'(wr3_cnt - w3), 64'd0);
        for (int i = 0; i < 3; i++)
            chk("m0_x", mem4[i], xw[i]);

        bad_hdr(hdr_word(0, 1, 1));
        bad_hdr(hdr_word(51, 1, 1));
        bad_hdr(hdr_word(2, 1, 17));
        bad_hdr(hdr_word(2, 51, 1));
        run_frame(2, 2, 1, 0, -1, 1'b0, cdummy);

        run_frame(50, 50, 16, 0, -1, 1'b0, cdummy);
        chk("big_last_a", 64'(last_a2), 64'd2499);
        chk("big_last_b", 64'(last_a3), 64'd2499);
        chk("big_t_b1", mem1[917], t_last);
        chk("big_t_b4", mem4[68], t_last);

        run_frame(3, 2, 2, 0, 11, 1'b0, cdummy);
        run_frame(3, 2, 2, 2, -1, 1'b0, cdummy);

        for (int r = 0; r < 6; r++) begin
            run_frame($urandom_range(1, 8), $urandom_range(0, 8),
                      $urandom_range(1, 16), 2, -1, 1'b0, cdummy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
